// File: rtl/hash_frame_transmitter_pkg.sv
// rtl/hash_frame_transmitter_pkg.sv - shared types and helpers for the hash frame transmitter
// Contents: frame state enum, default sync byte, counter width helper.
package hash_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Payload byte index width; never narrower than one bit.
  function automatic int cnt_width(input int n_bytes);
    return (n_bytes <= 2) ? 1 : $clog2(n_bytes);
  endfunction

endpackage

// File: rtl/hash_frame_transmitter_if.sv
// rtl/hash_frame_transmitter_if.sv - request and byte-stream bundle of the hash frame transmitter
// Signals: Start/HashValue request, Byte/Valid/Ready/Last stream, Busy and Z status.
// master = transmitter side, slave = hash engine plus byte sink side.
interface hash_frame_transmitter_if #(
  parameter int HASH_BYTES = 8
);
  logic                    Start;
  logic [8*HASH_BYTES-1:0] HashValue;
  logic [7:0]              Byte;
  logic                    Valid;
  logic                    Ready;
  logic                    Last;
  logic                    Busy;
  logic                    Z;

  modport master (
    input  Start, HashValue, Ready,
    output Byte, Valid, Last, Busy, Z
  );

  modport slave (
    output Start, HashValue, Ready,
    input  Byte, Valid, Last, Busy, Z
  );
endinterface

// File: rtl/hash_frame_transmitter_byte_shifter.sv
// rtl/hash_frame_transmitter_byte_shifter.sv - hash word holding register presenting one payload byte at a time
// Ports: clk, rst (sync, active-high), load/data capture the word, shift advances
// one byte, cur_byte is the byte at the send end.
module hash_byte_shifter #(
  parameter int HASH_BYTES = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    shift,
  input  logic [8*HASH_BYTES-1:0] data,
  output logic [7:0]              cur_byte
);
  localparam int W = 8 * HASH_BYTES;

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      // The send end is the top byte for MSB-first, the bottom byte otherwise.
      sr <= MSB_FIRST ? {sr[W-9:0], 8'h00} : {8'h00, sr[W-1:8]};
    end
  end

  assign cur_byte = MSB_FIRST ? sr[W-1 -: 8] : sr[7:0];
endmodule

// File: rtl/hash_frame_transmitter.sv
// rtl/hash_frame_transmitter.sv - frames a captured hash word as sync, payload, XOR checksum bytes
// Ports: Clock, Reset (sync, active-high), bus (master modport): Start/HashValue
// request, Byte/Valid/Ready/Last output stream, Busy while a frame is in flight,
// Z one-cycle pulse after the final handshake.
module hash_frame_transmitter
  import hash_tx_pkg::*;
#(
  parameter int         HASH_BYTES = 8,
  parameter bit         MSB_FIRST  = 1'b1,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input logic                      Clock,
  input logic                      Reset,
  hash_frame_transmitter_if.master bus
);
  localparam int             CW       = cnt_width(HASH_BYTES);
  localparam logic [CW-1:0]  LAST_IDX = CW'(HASH_BYTES - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic [7:0]    csum;
  logic [7:0]    cur_byte;
  logic          z_q;
  logic          load, shift, frame_done;
  logic [7:0]    byte_c;
  logic          valid_c, last_c;

  hash_byte_shifter #(
    .HASH_BYTES (HASH_BYTES),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shifter (
    .clk      (Clock),
    .rst      (Reset),
    .load     (load),
    .shift    (shift),
    .data     (bus.HashValue),
    .cur_byte (cur_byte)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Outputs decode only from registered state, so nothing combinational reaches
  // the stream from Ready or Start, and a stall simply holds every register.
  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    shift      = 1'b0;
    frame_done = 1'b0;
    byte_c     = 8'h00;
    valid_c    = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          load     = 1'b1;
          state_nx = SYNC;
        end
      end
      SYNC: begin
        byte_c  = SYNC_BYTE;
        valid_c = 1'b1;
        if (bus.Ready) state_nx = DATA;
      end
      DATA: begin
        byte_c  = cur_byte;
        valid_c = 1'b1;
        if (bus.Ready) begin
          shift = 1'b1;
          if (cnt == LAST_IDX) state_nx = CHECK;
        end
      end
      CHECK: begin
        byte_c  = csum;
        valid_c = 1'b1;
        last_c  = 1'b1;
        if (bus.Ready) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt  <= '0;
      csum <= 8'h00;
      z_q  <= 1'b0;
    end else begin
      z_q <= frame_done;
      if (load) begin
        cnt  <= '0;
        csum <= 8'h00;
      end else if (shift) begin
        cnt  <= cnt + CW'(1);
        csum <= csum ^ cur_byte;
      end
    end
  end

  assign bus.Byte  = byte_c;
  assign bus.Valid = valid_c;
  assign bus.Last  = last_c;
  assign bus.Busy  = valid_c;
  assign bus.Z     = z_q;
endmodule
